// File: rtl/peak_pkg.sv
// Shared types and widths for the spectral peak-frame sequencer.
// Exports: seq_state_t, peak_t, BIN_W, PEAK_W, BIN_IDX_W, SLOT_W.
package peak_pkg;

    localparam int BIN_W     = 25;
    localparam int PEAK_W    = 9;
    localparam int BIN_IDX_W = 9;
    localparam int SLOT_W    = 4;

    typedef logic [PEAK_W-1:0] peak_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        PAD,
        DRAIN,
        START,
        WAIT,
        EMIT
    } seq_state_t;

endpackage

// File: rtl/peak_out_serializer.sv
// Latches one frame of engine peaks and streams them out one per
// valid/ready handshake, rank 0 first.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   capture         - latch peaks (or zeros if zero_fill) and start
//   zero_fill       - latch all-zero peaks instead of engine data
//   peaks           - flat engine array, slot i at [i*PEAK_W +: PEAK_W]
//   out_ready       - downstream accepts
//   out_valid/out_peak/out_slot/out_last - output word
//   done            - final word handshake taking place this cycle
module peak_out_serializer
    import peak_pkg::*;
#(
    parameter int MAXIMAS_COUNT = 11
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            capture,
    input  logic                            zero_fill,
    input  logic [MAXIMAS_COUNT*PEAK_W-1:0] peaks,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [PEAK_W-1:0]               out_peak,
    output logic [SLOT_W-1:0]               out_slot,
    output logic                            out_last,
    output logic                            done
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(MAXIMAS_COUNT - 1);

    peak_t             lat [MAXIMAS_COUNT];
    logic [SLOT_W-1:0] slot;
    logic              valid;
    logic              last_slot;

    assign last_slot = (slot == LAST_SLOT);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            slot  <= '0;
            for (int i = 0; i < MAXIMAS_COUNT; i++) begin
                lat[i] <= '0;
            end
        end else if (capture) begin
            valid <= 1'b1;
            slot  <= '0;
            for (int i = 0; i < MAXIMAS_COUNT; i++) begin
                lat[i] <= zero_fill ? '0 : peaks[i*PEAK_W +: PEAK_W];
            end
        end else if (valid && out_ready) begin
            if (last_slot) begin
                valid <= 1'b0;
                slot  <= '0;
            end else begin
                slot <= slot + 1'b1;
            end
        end
    end

    // Stale peaks of the previous frame are hidden while idle.
    assign out_valid = valid;
    assign out_peak  = valid ? lat[slot] : '0;
    assign out_slot  = slot;
    assign out_last  = valid & last_slot;
    assign done      = valid & out_ready & last_slot;

endmodule

// File: rtl/peak_frame_sequencer.sv
// Sequences the peak-finder engine one FFT frame at a time: clear,
// load BINS bins (zero-padding short frames, draining long ones),
// start, wait for done, then stream MAXIMAS_COUNT tagged peaks.
// Optional WAIT watchdog: define PEAK_SEQ_TIMEOUT_EN.
// Ports:
//   clk, reset                     - clock, sync active-high reset
//   bin_valid/bin_ready/bin_data/bin_last - magnitude bin stream in
//   pk_reset/pk_load/pk_data/pk_start     - engine control
//   pk_done, pk_peaks              - engine result (flat 9-bit slots)
//   out_valid/out_ready/out_peak/out_slot/out_last/out_frame_id
//                                  - peak word stream out
//   frame_err                      - short/long frame or timeout pulse
module peak_frame_sequencer
    import peak_pkg::*;
#(
    parameter int BINS           = 512,
    parameter int MAXIMAS_COUNT  = 11,
    parameter int FRAME_ID_W     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            bin_valid,
    output logic                            bin_ready,
    input  logic [BIN_W-1:0]                bin_data,
    input  logic                            bin_last,
    output logic                            pk_reset,
    output logic                            pk_load,
    output logic [BIN_W-1:0]                pk_data,
    output logic                            pk_start,
    input  logic                            pk_done,
    input  logic [MAXIMAS_COUNT*PEAK_W-1:0] pk_peaks,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PEAK_W-1:0]               out_peak,
    output logic [SLOT_W-1:0]               out_slot,
    output logic                            out_last,
    output logic [FRAME_ID_W-1:0]           out_frame_id,
    output logic                            frame_err
);

    localparam int CNT_W = BIN_IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(BINS - 1);

    seq_state_t state, state_nx;

    logic [CNT_W-1:0]      bin_cnt;
    logic [FRAME_ID_W-1:0] frame_id;
    logic                  load_q;
    logic [BIN_W-1:0]      data_q;
    logic                  start_q;
    logic                  err_q;

    logic ld_hs;
    logic pad_load;
    logic err_evt;
    logic capture;
    logic zero_fill;
    logic emit_done;
    logic timeout;

`ifdef PEAK_SEQ_TIMEOUT_EN
    logic [15:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != WAIT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    // wd_cnt is 0 on the first WAIT cycle, so this fires on
    // WAIT cycle number TIMEOUT_CYCLES.
    assign timeout = (state == WAIT) && !pk_done &&
                     (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    assign ld_hs = (state == LOAD) && bin_valid;

    always_comb begin
        state_nx  = state;
        bin_ready = 1'b0;
        pad_load  = 1'b0;
        err_evt   = 1'b0;
        capture   = 1'b0;
        zero_fill = 1'b0;
        unique case (state)
            IDLE: begin
                if (bin_valid) state_nx = CLEAR;
            end
            CLEAR: begin
                state_nx = LOAD;
            end
            LOAD: begin
                bin_ready = 1'b1;
                if (bin_valid) begin
                    if (bin_cnt == LAST_BIN) begin
                        state_nx = bin_last ? START : DRAIN;
                        err_evt  = !bin_last;
                    end else if (bin_last) begin
                        state_nx = PAD;
                        err_evt  = 1'b1;
                    end
                end
            end
            PAD: begin
                pad_load = 1'b1;
                if (bin_cnt == LAST_BIN) state_nx = START;
            end
            DRAIN: begin
                bin_ready = 1'b1;
                if (bin_valid && bin_last) state_nx = START;
            end
            START: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (pk_done) begin
                    capture  = 1'b1;
                    state_nx = EMIT;
                end else if (timeout) begin
                    capture   = 1'b1;
                    zero_fill = 1'b1;
                    err_evt   = 1'b1;
                    state_nx  = EMIT;
                end
            end
            EMIT: begin
                if (emit_done) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (reset) bin_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bin_cnt  <= '0;
            frame_id <= '0;
            load_q   <= 1'b0;
            data_q   <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            load_q  <= ld_hs || pad_load;
            start_q <= (state == START);
            err_q   <= err_evt;
            if (ld_hs) begin
                data_q <= bin_data;
            end else if (pad_load) begin
                data_q <= '0;
            end
            if (state == CLEAR) begin
                bin_cnt <= '0;
            end else if (ld_hs || pad_load) begin
                bin_cnt <= bin_cnt + 1'b1;
            end
            if (emit_done) frame_id <= frame_id + 1'b1;
        end
    end

    // Load and start are both delayed one cycle, so the final load
    // reaches the engine during START and the start pulse follows it
    // in the next cycle; the two never coincide.
    assign pk_reset     = reset || (state == CLEAR) || timeout;
    assign pk_load      = load_q;
    assign pk_data      = data_q;
    assign pk_start     = start_q;
    assign frame_err    = err_q;
    assign out_frame_id = frame_id;

    peak_out_serializer #(
        .MAXIMAS_COUNT(MAXIMAS_COUNT)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .capture  (capture),
        .zero_fill(zero_fill),
        .peaks    (pk_peaks),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_peak (out_peak),
        .out_slot (out_slot),
        .out_last (out_last),
        .done     (emit_done)
    );

endmodule

// File: tb/tb_peak_frame_sequencer.sv
// Directed bench for peak_frame_sequencer with a behavioural engine:
// exact, short, long, backpressured and reset-interrupted frames.
module tb_peak_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bin_valid = 1'b0;
    logic        bin_ready;
    logic [24:0] bin_data = '0;
    logic        bin_last = 1'b0;
    logic        pk_reset;
    logic        pk_load;
    logic [24:0] pk_data;
    logic        pk_start;
    logic        pk_done = 1'b0;
    logic [98:0] pk_peaks = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  out_peak;
    logic [3:0]  out_slot;
    logic        out_last;
    logic [15:0] out_frame_id;
    logic        frame_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    peak_frame_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .bin_valid   (bin_valid),
        .bin_ready   (bin_ready),
        .bin_data    (bin_data),
        .bin_last    (bin_last),
        .pk_reset    (pk_reset),
        .pk_load     (pk_load),
        .pk_data     (pk_data),
        .pk_start    (pk_start),
        .pk_done     (pk_done),
        .pk_peaks    (pk_peaks),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_peak    (out_peak),
        .out_slot    (out_slot),
        .out_last    (out_last),
        .out_frame_id(out_frame_id),
        .frame_err   (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // engine model + monitors, all sampled on the falling edge
    logic [8:0] mem [512];
    int eng_n = 0;
    int dly = 0;
    int ld_tot = 0, st_tot = 0, ovl_tot = 0, err_tot = 0, w_tot = 0;
    logic [8:0] w_peak [128];
    logic [3:0] w_slot [128];
    logic       w_last [128];
    logic [15:0] w_fid [128];
    bit   bp_en = 0;
    int   bp_cnt = 0, bp_bad = 0;
    logic [8:0] bp_peak;
    logic [3:0] bp_slot;
    bit   used [256];
    int   bi, bv;

    always @(negedge clk) begin
        if (pk_load) ld_tot++;
        if (pk_start) st_tot++;
        if (pk_load && pk_start) ovl_tot++;
        if (frame_err) err_tot++;
        if (pk_reset) begin
            eng_n = 0;
            dly = 0;
            pk_done = 1'b0;
        end else begin
            if (pk_load) begin
                if (eng_n < 512) mem[eng_n] = pk_data[24:16];
                eng_n++;
            end
            if (pk_start) begin
                dly = 20;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    // 11 largest odd-indexed bins, descending
                    for (int i = 0; i < 256; i++) used[i] = 0;
                    for (int s = 0; s < 11; s++) begin
                        bi = 0;
                        bv = -1;
                        for (int i = 0; i < 256; i++) begin
                            if (!used[i] && int'(mem[2*i+1]) > bv) begin
                                bv = int'(mem[2*i+1]);
                                bi = i;
                            end
                        end
                        used[bi] = 1;
                        pk_peaks[s*9 +: 9] = mem[2*bi+1];
                    end
                    pk_done = 1'b1;
                end
            end
        end
        if (!bp_en) bp_cnt = 0;
        if ((bp_cnt > 0 && bp_cnt < 5) ||
            (bp_en && bp_cnt == 0 && out_valid && out_slot == 4'd3)) begin
            out_ready = 1'b0;
            if (bp_cnt == 0) begin
                bp_peak = out_peak;
                bp_slot = out_slot;
            end else if (!out_valid || out_peak !== bp_peak ||
                         out_slot !== bp_slot) begin
                bp_bad++;
            end
            bp_cnt++;
        end else begin
            out_ready = 1'b1;
        end
        if (out_valid && out_ready && w_tot < 128) begin
            w_peak[w_tot] = out_peak;
            w_slot[w_tot] = out_slot;
            w_last[w_tot] = out_last;
            w_fid[w_tot]  = out_frame_id;
            w_tot++;
        end
    end

    task automatic send_bins(input int n, input int last_at,
                             output int acc);
        int w;
        bit ok;
        acc = 0;
        ok = 1;
        for (int k = 0; k < n && ok; k++) begin
            bin_valid = 1'b1;
            bin_data  = 25'((k % 512) << 16);
            bin_last  = (k == last_at);
            w = 0;
            @(negedge clk);
            while (!bin_ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!bin_ready) begin
                check("bin_hs", {31'd0, bin_ready}, 32'd1);
                ok = 0;
            end else begin
                @(posedge clk);
                #1;
                acc++;
            end
        end
        bin_valid = 1'b0;
        bin_last  = 1'b0;
    endtask

    task automatic run_frame(input string nm, input int n, input int top,
                             input int nvalid, input int exp_err,
                             input int exp_fid);
        int lb, sb, eb, wb, acc, w, bad;
        lb = ld_tot;
        sb = st_tot;
        eb = err_tot;
        wb = w_tot;
        send_bins(n, n - 1, acc);
        check({nm, "_accepted"}, acc, n);
        w = 0;
        while (w_tot - wb < 11 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_loads"}, ld_tot - lb, 512);
        check({nm, "_starts"}, st_tot - sb, 1);
        check({nm, "_err"}, err_tot - eb, exp_err);
        check({nm, "_words"}, w_tot - wb, 11);
        check({nm, "_ld_st_overlap"}, ovl_tot, 0);
        for (int s = 0; s < 11; s++) begin
            check($sformatf("%s_peak%0d", nm, s), w_peak[wb+s], top - 2*s);
            check($sformatf("%s_slot%0d", nm, s), w_slot[wb+s], s);
            check($sformatf("%s_last%0d", nm, s), w_last[wb+s], s == 10);
            check($sformatf("%s_fid%0d", nm, s), w_fid[wb+s], exp_fid);
        end
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            if (mem[k] !== 9'((k < nvalid) ? k : 0)) bad++;
        end
        check({nm, "_engine_mem"}, bad, 0);
    endtask

    initial begin
        int acc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pk_reset", pk_reset, 1);
        check("rst_bin_ready", bin_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_pk_load", pk_load, 0);
        check("rst_pk_start", pk_start, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_id", out_frame_id, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_pk_reset", pk_reset, 0);
        @(posedge clk);
        #1;

        run_frame("exact", 512, 511, 512, 0, 0);
        run_frame("short", 100, 99, 100, 1, 1);
        run_frame("long", 600, 511, 512, 1, 2);

        bp_en = 1;
        run_frame("bp", 512, 511, 512, 0, 3);
        check("bp_stall_cycles", bp_cnt, 5);
        check("bp_stable", bp_bad, 0);
        bp_en = 0;

        send_bins(200, -1, acc);
        check("rst_mid_accepted", acc, 200);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_pk_reset", pk_reset, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_bin_ready", bin_ready, 0);
        check("rst_mid_frame_id", out_frame_id, 0);
        check("rst_mid_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        run_frame("after_rst", 512, 511, 512, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
